// File: rtl/tlb_flush_queue_if.sv
// tlb_flush_queue_if
//   Groups the fence-issue, commit/flush control and TLB flush-channel signals
//   of tlb_flush_queue. Signal suffixes (_i/_o) are from the queue's point of view.
//   slave  : the queue itself (consumes fences and acks, drives requests/payload)
//   master : the execute stage / TLB side driving the queue
interface tlb_flush_queue_if #(
    parameter int NR_TLBS    = 2,
    parameter int XLEN       = 64,
    parameter int ADDR_WIDTH = 41,
    parameter int ASID_WIDTH = 16,
    parameter int VMID_WIDTH = 14
);
    logic                  flush_i;
    logic                  fence_valid_i;
    logic                  fence_ready_o;
    logic [1:0]            fence_op_i;
    logic [XLEN-1:0]       rs1_i;
    logic [XLEN-1:0]       rs2_i;
    logic                  rs1_zero_i;
    logic                  rs2_zero_i;
    logic                  v_i;
    logic [VMID_WIDTH-1:0] vmid_i;
    logic                  commit_i;
    logic [NR_TLBS-1:0]    tlb_flush_req_o;
    logic [NR_TLBS-1:0]    tlb_flush_ack_i;
    logic [ADDR_WIDTH-1:0] flush_addr_o;
    logic [ASID_WIDTH-1:0] flush_asid_o;
    logic [VMID_WIDTH-1:0] flush_vmid_o;
    logic                  flush_all_addr_o;
    logic                  flush_all_id_o;
    logic [1:0]            flush_type_o;
    logic                  empty_o;

    modport slave (
        input  flush_i, fence_valid_i, fence_op_i, rs1_i, rs2_i, rs1_zero_i,
               rs2_zero_i, v_i, vmid_i, commit_i, tlb_flush_ack_i,
        output fence_ready_o, tlb_flush_req_o, flush_addr_o, flush_asid_o,
               flush_vmid_o, flush_all_addr_o, flush_all_id_o, flush_type_o,
               empty_o
    );

    modport master (
        output flush_i, fence_valid_i, fence_op_i, rs1_i, rs2_i, rs1_zero_i,
               rs2_zero_i, v_i, vmid_i, commit_i, tlb_flush_ack_i,
        input  fence_ready_o, tlb_flush_req_o, flush_addr_o, flush_asid_o,
               flush_vmid_o, flush_all_addr_o, flush_all_id_o, flush_type_o,
               empty_o
    );
endinterface

// File: rtl/tlb_flush_queue.sv
// tlb_flush_queue
//   Queue of decoded SFENCE.VMA / HFENCE.VVMA / HFENCE.GVMA operands. Fences are
//   captured at issue, marked committed in order by the scoreboard, and the
//   committed head is broadcast to NR_TLBS flush channels, each of which must
//   acknowledge once before the head pops. A pipeline flush discards only the
//   uncommitted tail of the queue.
// Ports
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus (slave)  : fence issue (valid/ready/op/rs1/rs2/zero flags/v/vmid),
//                  commit_i, flush_i, per-channel req/ack, head payload, empty_o
module tlb_flush_queue #(
    parameter int DEPTH      = 2,
    parameter int NR_TLBS    = 2,
    parameter int XLEN       = 64,
    parameter int ADDR_WIDTH = 41,
    parameter int ASID_WIDTH = 16,
    parameter int VMID_WIDTH = 14
) (
    input  logic              clk_i,
    input  logic              rst_i,
    tlb_flush_queue_if.slave  bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Entry storage (payload only, no reset needed)
    logic [ADDR_WIDTH-1:0] ent_addr_q     [DEPTH];
    logic [ASID_WIDTH-1:0] ent_asid_q     [DEPTH];
    logic [VMID_WIDTH-1:0] ent_vmid_q     [DEPTH];
    logic [1:0]            ent_type_q     [DEPTH];
    logic                  ent_all_addr_q [DEPTH];
    logic                  ent_all_id_q   [DEPTH];

    // head: oldest entry; cmt: first uncommitted entry; tail: next free slot
    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d, cmt_q, cmt_d;
    logic [CNT_W-1:0]   count_q, count_d, ncmt_q, ncmt_d;
    logic [NR_TLBS-1:0] acked_q, acked_d;

    logic [ADDR_WIDTH-1:0] new_addr_d;
    logic [ASID_WIDTH-1:0] new_asid_d;
    logic [VMID_WIDTH-1:0] new_vmid_d;
    logic [1:0]            new_type_d;

    logic                  empty, head_committed, alloc, commit_eff, pop;
    logic [NR_TLBS-1:0]    req, done;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Operand decode for the fence being issued this cycle
    always_comb begin
        new_type_d = 2'd0;
        new_addr_d = ADDR_WIDTH'(bus.rs1_i);
        new_asid_d = ASID_WIDTH'(bus.rs2_i);
        new_vmid_d = '0;
        case (bus.fence_op_i)
            2'd0: begin
                // SFENCE.VMA executed in a guest acts on the VS stage
                if (bus.v_i) begin
                    new_type_d = 2'd1;
                    new_vmid_d = bus.vmid_i;
                end
            end
            2'd1: begin
                new_type_d = 2'd1;
                new_vmid_d = bus.vmid_i;
            end
            2'd2: begin
                // GVMA rs1 carries a guest physical address shifted right by 2
                new_type_d = 2'd2;
                new_addr_d = ADDR_WIDTH'({bus.rs1_i, 2'b00});
                new_vmid_d = VMID_WIDTH'(bus.rs2_i);
                new_asid_d = '0;
            end
            default: ;
        endcase
    end

    // Queue control
    always_comb begin
        empty          = (count_q == '0);
        head_committed = (ncmt_q != '0);
        bus.fence_ready_o = (count_q < CNT_W'(DEPTH));
        alloc      = bus.fence_valid_i & bus.fence_ready_o & ~bus.flush_i &
                     (bus.fence_op_i != 2'd3);
        // Only entries already held can be committed, never this cycle's allocation
        commit_eff = bus.commit_i & (count_q != ncmt_q);
        req        = {NR_TLBS{head_committed}} & ~acked_q;
        done       = acked_q | (req & bus.tlb_flush_ack_i);
        pop        = head_committed & (&done);

        head_d  = pop ? ptr_inc(head_q) : head_q;
        cmt_d   = commit_eff ? ptr_inc(cmt_q) : cmt_q;
        ncmt_d  = ncmt_q + CNT_W'(commit_eff) - CNT_W'(pop);
        acked_d = pop ? '0 : done;

        if (bus.flush_i) begin
            // Rewind to the committed boundary after this cycle's commit
            tail_d  = cmt_d;
            count_d = ncmt_d;
        end else begin
            tail_d  = alloc ? ptr_inc(tail_q) : tail_q;
            count_d = count_q + CNT_W'(alloc) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            cmt_q   <= '0;
            count_q <= '0;
            ncmt_q  <= '0;
            acked_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            cmt_q   <= cmt_d;
            count_q <= count_d;
            ncmt_q  <= ncmt_d;
            acked_q <= acked_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (alloc) begin
            ent_addr_q[tail_q]     <= new_addr_d;
            ent_asid_q[tail_q]     <= new_asid_d;
            ent_vmid_q[tail_q]     <= new_vmid_d;
            ent_type_q[tail_q]     <= new_type_d;
            ent_all_addr_q[tail_q] <= bus.rs1_zero_i;
            ent_all_id_q[tail_q]   <= bus.rs2_zero_i;
        end
    end

    always_comb begin
        bus.tlb_flush_req_o  = req;
        bus.empty_o          = empty;
        bus.flush_addr_o     = empty ? '0   : ent_addr_q[head_q];
        bus.flush_asid_o     = empty ? '0   : ent_asid_q[head_q];
        bus.flush_vmid_o     = empty ? '0   : ent_vmid_q[head_q];
        bus.flush_type_o     = empty ? 2'd0 : ent_type_q[head_q];
        bus.flush_all_addr_o = empty ? 1'b0 : ent_all_addr_q[head_q];
        bus.flush_all_id_o   = empty ? 1'b0 : ent_all_id_q[head_q];
    end
endmodule

// File: doc/tlb_flush_queue.md
# tlb_flush_queue

Parametrised fence-operand queue for the execute stage. It captures SFENCE.VMA, HFENCE.VVMA and HFENCE.GVMA operands at issue and holds them until the scoreboard commits each fence. It then drives an acknowledged flush request to `NR_TLBS` TLB channels (ITLB, DTLB, optional shared L2 TLB). It supersedes the single-entry, single-mode, unacknowledged sfence operand register: it adds queue depth, hypervisor fence modes, survival of committed entries across pipeline flushes, and per-channel handshakes.

## Interface
- `DEPTH`, 2: queue entries, ≥1, any value (no power-of-two requirement).
- `NR_TLBS`, 2: flush channels, ≥1.
- `XLEN`, 64: operand width.
- `ADDR_WIDTH`, 41: flush address width, ≤ XLEN.
- `ASID_WIDTH`, 16 / `VMID_WIDTH`, 14: identifier widths.
- `clk_i` in 1: clock.
- `rst_i` in 1: synchronous, active-high reset.
- `flush_i` in 1: pipeline flush; drops uncommitted entries.
- `fence_valid_i` in 1: fence issued this cycle.
- `fence_ready_o` out 1: entry free.
- `fence_op_i` in 2: 0 SFENCE.VMA, 1 HFENCE.VVMA, 2 HFENCE.GVMA; 3 is reserved and ignored.
- `rs1_i` in XLEN: address operand.
- `rs2_i` in XLEN: ASID/VMID operand.
- `rs1_zero_i` in 1: rs1 is x0.
- `rs2_zero_i` in 1: rs2 is x0.
- `v_i` in 1: current virtualization mode.
- `vmid_i` in VMID_WIDTH: current hgatp.VMID.
- `commit_i` in 1: oldest uncommitted fence retired.
- `tlb_flush_req_o` out NR_TLBS: per-channel request.
- `tlb_flush_ack_i` in NR_TLBS: per-channel acknowledge.
- `flush_addr_o` out ADDR_WIDTH: flush address payload.
- `flush_asid_o` out ASID_WIDTH: flush ASID payload.
- `flush_vmid_o` out VMID_WIDTH: flush VMID payload.
- `flush_all_addr_o` out 1: flush all addresses.
- `flush_all_id_o` out 1: flush all ASIDs/VMIDs.
- `flush_type_o` out 2: 0 S-stage bare, 1 VS-stage, 2 G-stage.
- `empty_o` out 1: no entries held.

## Operation

**Capture**
- An entry is allocated when `fence_valid_i & fence_ready_o & ~flush_i & fence_op_i!=3`.
- `fence_ready_o = (count < DEPTH)`. It is combinational and independent of `flush_i`.

**Decode at capture**
- SFENCE.VMA with `v_i=0`:
  - type 0; addr = `rs1_i[ADDR_WIDTH-1:0]`; asid = `rs2_i[ASID_WIDTH-1:0]`; vmid = 0.
- SFENCE.VMA with `v_i=1`, and HFENCE.VVMA:
  - type 1; addr and asid as above; vmid = `vmid_i` sampled at capture.
- HFENCE.GVMA:
  - type 2; addr = `{rs1_i,2'b00}[ADDR_WIDTH-1:0]`; vmid = `rs2_i[VMID_WIDTH-1:0]`; asid = 0.
- For all ops: all_addr = `rs1_zero_i`; all_id = `rs2_zero_i`.

**Queue structure**
- Circular buffer with head, tail, a committed-boundary pointer and `count`. Pointers wrap at DEPTH.
- `commit_i` marks the oldest uncommitted entry as committed.
  - It never applies to an entry allocated in the same cycle.
  - `commit_i` with no uncommitted entry is ignored; the bench flags it as a protocol error.

**Issue** (head entry committed)
- `tlb_flush_req_o[c] = head_committed & ~acked[c]`.
- A channel is done when req and ack are both high in the same cycle; its `acked[c]` bit sets.
- Ack while req is low is ignored.
- When all channels are done (including final acks arriving in the same cycle):
  - the head pops at that edge;
  - `acked` clears;
  - the next committed entry may request in the following cycle.
- Payload outputs show the head entry. They are stable from the first req until pop. They are 0 when empty.

**Flush** (`flush_i`)
- Tail rewinds to the committed boundary; uncommitted entries are discarded; count is adjusted.
- Committed entries and the in-progress handshake are unaffected.
- `commit_i` in the same cycle is applied first, so the newly committed entry survives.
- Allocation is blocked that cycle.

**Simultaneous events**
- Allocate and pop in the same cycle is allowed.
- When the queue is full and the head pops, `fence_ready_o` was 0 that cycle. The new fence is not taken and must be reissued by the stall logic.

**Reset**
- Empties the queue, clears `acked`, and zeroes the pointers.

## Timing
- Reset values:
  - `tlb_flush_req_o` = 0; all payload outputs = 0;
  - `empty_o` = 1; `fence_ready_o` = 1.
- Capture to allocation: edge at the end of the `fence_valid_i` cycle.
- Commit at cycle t → req high at t+1.
- Minimum handshake, ack at t+1 on all channels → pop at the end of t+1; `empty_o` = 1 at t+2.
- Back-to-back committed entries give one flush per cycle when channels ack immediately.
- `rst_i` mid-handshake: req drops on the cycle after the reset edge; no pop completes.
- Outputs are registered-state decodes only. There is no combinational path from `tlb_flush_ack_i` to `tlb_flush_req_o` other than the acked mask update.

## Test plan
- **Basic SFENCE flush.** Inputs: `v_i=0`, SFENCE, `rs1_i=0x8000_1000`, `rs2_i=5`; commit at t; both channels ack at t+1.
  - Required: type 0, addr 0x8000_1000, asid 5, all flags 0; req 2'b11 only at t+1; `empty_o`=1 at t+2.
- **Staggered acks.** ITLB acks at t+1, DTLB at t+4.
  - Required: req[0] low from t+2; req[1] high t+1..t+4; pop at the end of t+4; payload stable throughout.
- **Flush keeps committed entries.** DEPTH=2: allocate A and B, commit A, then assert `flush_i` with no commit.
  - Required: B dropped, A flushed; `count` = 1 after the flush.
- **Commit during flush.** Repeat the previous scenario with `commit_i` asserted in the flush cycle.
  - Required: both A and B are flushed, in order.
- **Hypervisor modes.**
  - `v_i=1`, SFENCE, `vmid_i=7` → type 1, vmid 7.
  - HFENCE.GVMA, `rs1_i=0x100`, `rs2_zero_i=1` → type 2, addr 0x400, all_id 1.
- **Full queue and reset.**
  - Fill DEPTH entries → `fence_ready_o`=0; an extra fence is not captured.
  - Assert `rst_i` mid-handshake → req 0, `empty_o`=1 the next cycle.
